hit_stream_buffer: RTL
======================

Name: hit_stream_buffer

Overview:
Downstream neighbour of the sample-test stage. It consumes the R18 hit stream (hit_R18S, color_R18U, hit_valid_R18H), buffers hit entries in a FIFO and presents them to the z-buffer/framebuffer writer over a valid/ready handshake. It raises a registered halt to the upstream rasterizer pipe before the FIFO overflows. It keeps saturating hit and drop counters for performance reporting.

Parameters:
SIGFIG, 24, bits per coordinate/colour word
RADIX, 10, fraction bits (pass-through only; no arithmetic)
AXIS, 3, coordinates per hit (x,y,z)
COLORS, 3, colour channels
MULTI_SAMP, 1, sample lanes per cycle
DEPTH, 8, FIFO entries; power of two, >= 4
SKID, 3, free slots still required when halt asserts; covers in-flight upstream stages; 1 <= SKID < DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
hit_R18S  in  [MULTI_SAMP][AXIS] x SIGFIG signed  per-lane hit position
color_R18U  in  [COLORS] x SIGFIG unsigned  triangle colour, shared by all lanes
hit_valid_R18H  in  [MULTI_SAMP] x 1  per-lane hit valid
halt_RnnH  out  1  backpressure to upstream pipe
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_hit  out  [MULTI_SAMP][AXIS] x SIGFIG  head entry positions
out_color  out  [COLORS] x SIGFIG  head entry colour
out_lane_mask  out  MULTI_SAMP  valid lanes of head entry
fill_count  out  $clog2(DEPTH)+1  current occupancy
hit_count  out  32  accepted lanes, saturating
drop_count  out  16  dropped entries, saturating
overflow_err  out  1  sticky drop indicator

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, fill_count=0, out_valid=0, halt_RnnH=0, hit_count=0, drop_count=0, overflow_err=0. Storage contents are don't-care; they need no reset.
- push_req = OR of hit_valid_R18H. Entry = {hit lanes, colour, lane mask = hit_valid_R18H}.
- pop = out_valid & out_ready.
- Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. full = same index, different wrap bit. empty = pointers equal.
- Push accepted when push_req & (!full | pop). A push while full with no pop drops the entry. On a drop: drop_count+1 (saturates at 0xFFFF), overflow_err set and held until reset. The dropped data never appears on the outputs.
- Show-ahead output: out_* driven from the head entry. out_valid = !empty. Output data is stable while out_valid & !out_ready.
- Latency: an entry pushed at edge N is visible with out_valid=1 in the cycle after edge N. There is no same-cycle bypass. Push and pop in the same cycle while empty is impossible because out_valid=0.
- Simultaneous push and pop while full: both proceed, fill stays DEPTH, no drop.
- fill_count next = fill + accepted_push - pop.
- halt_RnnH is a registered signal, set at each edge to (fill_next >= DEPTH-SKID).
- hit_count += popcount(lane mask) for each accepted push. It saturates at 0xFFFFFFFF and never wraps.
- Data words pass through unmodified; no sign or width change.
- The consumer must ignore out_hit, out_color and out_lane_mask when out_valid=0.

Decomposition:
- Package hit_buf_pkg holds:
  - default-width localparams (SIGFIG, AXIS, COLORS)
  - the saturation limits HIT_CNT_MAX and DROP_CNT_MAX
  - a pointer-width helper function
- Sub-module hit_fifo_ctrl (parameter DEPTH) contains the pointers, full/empty, fill count and the accept/drop decision. The top level contains the storage array, halt register and counters.

Test Plan:
- Reset: hold rst=0 for 3 cycles with hit_valid_R18H=1 -> all outputs 0, fill_count=0; no entry is accepted.
- Single hit, out_ready=1: push x=0x000400, y=0x000800, z=0x000100, colour {0xFFF,0,0} -> out_valid=1 next cycle with identical data, then 0. fill_count goes 1 then 0. hit_count=1.
- Halt threshold (DEPTH=8, SKID=3), out_ready=0: push one entry per cycle -> halt_RnnH=1 in the cycle after the 5th push. It drops to 0 the cycle after a pop takes fill from 5 to 4.
- Overflow: out_ready=0, 9 consecutive pushes -> fill_count=8, drop_count=1, overflow_err=1. Draining 8 pops returns entries 1..8 in order; entry 9 never appears.
- Full with simultaneous push and pop -> fill stays 8, drop_count unchanged, order preserved.
- MULTI_SAMP=2 with mask 2'b10, then 2'b11 -> hit_count=3, and out_lane_mask matches per entry. Asserting rst=0 mid-stream with fill=4 -> out_valid=0 and fill_count=0 immediately, counters=0.

Source files
------------

// File: rtl/hit_buf_pkg.sv
// Shared widths, counter saturation limits and pointer sizing for the hit stream buffer.
package hit_buf_pkg;

  localparam int SIGFIG_DEF = 24;
  localparam int AXIS_DEF   = 3;
  localparam int COLORS_DEF = 3;

  localparam logic [31:0] HIT_CNT_MAX  = 32'hFFFF_FFFF;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hit_fifo_ctrl.sv
// Wrap-bit FIFO pointer control: full/empty, occupancy and the accept/drop decision.
module hit_fifo_ctrl
  import hit_buf_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = ptr_width(DEPTH),
  localparam int AW    = PW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push_req,
  input  logic          i_pop,
  output logic          o_push,
  output logic          o_drop,
  output logic [AW-1:0] o_wr_idx,
  output logic [AW-1:0] o_rd_idx,
  output logic          o_empty,
  output logic          o_full,
  output logic [PW-1:0] o_fill,
  output logic [PW-1:0] o_fill_next
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  assign o_wr_idx = r_wr_ptr[AW-1:0];
  assign o_rd_idx = r_rd_ptr[AW-1:0];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop in the same cycle frees the slot the push needs, so full alone does not drop.
  assign o_push = i_push_req && (!o_full || i_pop);
  assign o_drop = i_push_req && o_full && !i_pop;

  assign o_fill      = r_wr_ptr - r_rd_ptr;
  assign o_fill_next = o_fill + PW'(o_push) - PW'(i_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/hit_stream_buffer.sv
// Buffers R18 hit entries for the z-buffer/framebuffer writer, with registered upstream halt
// and saturating hit/drop counters.
module hit_stream_buffer
  import hit_buf_pkg::*;
#(
  parameter  int SIGFIG     = SIGFIG_DEF,
  parameter  int RADIX      = 10,
  parameter  int AXIS       = AXIS_DEF,
  parameter  int COLORS     = COLORS_DEF,
  parameter  int MULTI_SAMP = 1,
  parameter  int DEPTH      = 8,
  parameter  int SKID       = 3,
  localparam int PW         = ptr_width(DEPTH),
  localparam int AW         = PW - 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic signed [MULTI_SAMP-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]             color_R18U,
  input  logic        [MULTI_SAMP-1:0]                     hit_valid_R18H,
  output logic                                            halt_RnnH,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [MULTI_SAMP-1:0][AXIS-1:0][SIGFIG-1:0] out_hit,
  output logic        [COLORS-1:0][SIGFIG-1:0]             out_color,
  output logic        [MULTI_SAMP-1:0]                     out_lane_mask,
  output logic        [PW-1:0]                             fill_count,
  output logic        [31:0]                               hit_count,
  output logic        [15:0]                               drop_count,
  output logic                                            overflow_err
);

  if (RADIX < 0 || RADIX >= SIGFIG || SKID < 1 || SKID >= DEPTH || DEPTH < 4 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("hit_stream_buffer: invalid parameter set");
  end

  logic [MULTI_SAMP-1:0][AXIS-1:0][SIGFIG-1:0] r_hit_mem  [DEPTH];
  logic [COLORS-1:0][SIGFIG-1:0]               r_color_mem[DEPTH];
  logic [MULTI_SAMP-1:0]                       r_mask_mem [DEPTH];

  logic          w_push_req, w_pop, w_push, w_drop, w_empty, w_full;
  logic [AW-1:0] w_wr_idx, w_rd_idx;
  logic [PW-1:0] w_fill, w_fill_next;
  logic [32:0]   w_hit_sum;
  logic          r_halt, r_ovf;
  logic [31:0]   r_hit_cnt;
  logic [15:0]   r_drop_cnt;

  // Output handshake: out_valid means the head entry is presented; it is consumed on a
  // rising edge where out_valid && out_ready, and held unchanged until then.
  assign w_push_req = |hit_valid_R18H;
  assign w_pop      = out_valid && out_ready;

  hit_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_push_req (w_push_req),
    .i_pop      (w_pop),
    .o_push     (w_push),
    .o_drop     (w_drop),
    .o_wr_idx   (w_wr_idx),
    .o_rd_idx   (w_rd_idx),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_fill     (w_fill),
    .o_fill_next(w_fill_next)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hit_mem[w_wr_idx]   <= hit_R18S;
      r_color_mem[w_wr_idx] <= color_R18U;
      r_mask_mem[w_wr_idx]  <= hit_valid_R18H;
    end
  end

  assign out_valid     = !w_empty;
  assign out_hit       = r_hit_mem[w_rd_idx];
  assign out_color     = r_color_mem[w_rd_idx];
  assign out_lane_mask = r_mask_mem[w_rd_idx];
  assign fill_count    = w_fill;

  // Lane increments are tiny, so bit 32 of the widened sum flags saturation.
  assign w_hit_sum = {1'b0, r_hit_cnt} + 33'($countones(hit_valid_R18H));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halt     <= 1'b0;
      r_ovf      <= 1'b0;
      r_hit_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_halt <= (w_fill_next >= PW'(DEPTH - SKID));
      if (w_push) r_hit_cnt <= w_hit_sum[32] ? HIT_CNT_MAX : w_hit_sum[31:0];
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign halt_RnnH    = r_halt;
  assign overflow_err = r_ovf;
  assign hit_count    = r_hit_cnt;
  assign drop_count   = r_drop_cnt;

  logic w_unused;
  assign w_unused = w_full;

endmodule
